bus_arb: RTL and testbench

Round-robin arbiter and transaction sequencer for the shared memory bus behind the processing elements. Up to NUM_REQ requesters (one per `pe`) post a read address. The arbiter grants one requester at a time and drives the shared bus address. It waits for the memory acknowledge, or aborts on timeout, then returns the captured bus data with a one-cycle completion pulse.

---
 rtl/bus_arb.sv | 177 +++++++++++++++++
 tb/tb_bus_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb.sv
`default_nettype none
// ============================================================================
// bus_arb : round-robin arbiter and read sequencer for the shared memory bus
// Revision: 1.0 - initial release
// ============================================================================
module bus_arb #(
  parameter int NUM_REQ   = 4,
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*AD_LEN-1:0] ad_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [BUS_WIDTH-1:0]      rdata_o,
  output logic [AD_LEN-1:0]         bus_ad_o,
  output logic                      bus_req_o,
  input  logic                      bus_ack_i,
  input  logic [BUS_WIDTH-1:0]      bus_data_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [NUM_REQ-1:0]     err_q, err_d;
  logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
  logic [AD_LEN-1:0]      bus_ad_q, bus_ad_d;
  logic                   bus_req_q, bus_req_d;

  logic [AD_LEN-1:0]      ad_arr [NUM_REQ];
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [AD_LEN-1:0]      win_ad;
  logic [IDX_W-1:0]       cand_idx;
  int                     cand;
  logic                   finish;
  logic                   timed_out;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ad_arr[g] = ad_i[g*AD_LEN +: AD_LEN];
  end

  // First requester found scanning upward from ptr_q, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_ad    = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
        win_ad    = ad_arr[cand_idx];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    bus_ad_d  = bus_ad_q;
    bus_req_d = bus_req_q;
    finish    = 1'b0;
    timed_out = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d     = '0;
        bus_req_d = 1'b0;
        bus_ad_d  = '0;
        if (win_found) begin
          idx_d          = win_idx;
          cnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          bus_req_d      = 1'b1;
          bus_ad_d       = win_ad;
          state_d        = BUSY;
        end
      end

      BUSY: begin
        // An ack on the final allowed cycle still counts as success.
        if (bus_ack_i) begin
          rdata_d = bus_data_i;
          finish  = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rdata_d   = '0;
          timed_out = 1'b1;
          finish    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (finish) begin
          gnt_d         = '0;
          bus_req_d     = 1'b0;
          bus_ad_d      = '0;
          done_d[idx_q] = 1'b1;
          err_d[idx_q]  = timed_out;
          state_d       = RESP;
        end
      end

      RESP: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = IDLE;
      end

      default: begin
        gnt_d     = '0;
        bus_req_d = 1'b0;
        bus_ad_d  = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      bus_ad_q  <= '0;
      bus_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      bus_ad_q  <= bus_ad_d;
      bus_req_q <= bus_req_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign bus_ad_o  = bus_ad_q;
  assign bus_req_o = bus_req_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arb.sv
`default_nettype none
// ============================================================================
// tb_bus_arb : directed vector bench for bus_arb (NUM_REQ=4, TIMEOUT=4)
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_arb;

  localparam logic [31:0] A0  = 32'hA000_0000;
  localparam logic [31:0] A1  = 32'hA000_0111;
  localparam logic [31:0] A2  = 32'h0000_1000;
  localparam logic [31:0] A3  = 32'hA000_0333;
  localparam logic [31:0] BAD = 32'hBAD0_0000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [127:0] ad;
  logic [3:0]   gnt_o, done_o, err_o;
  logic [31:0]  rdata_o, bus_ad_o;
  logic         bus_req_o;
  logic         ack;
  logic [31:0]  data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  req;
    logic        ack;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [31:0] rdata;
    logic [31:0] bus_ad;
    logic        bus_req;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  bus_arb #(
    .NUM_REQ  (4),
    .AD_LEN   (32),
    .BUS_WIDTH(32),
    .TIMEOUT  (4)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_n),
    .req_i     (req),
    .ad_i      (ad),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .bus_ad_o  (bus_ad_o),
    .bus_req_o (bus_req_o),
    .bus_ack_i (ack),
    .bus_data_i(data)
  );

  task automatic add(input logic [3:0] r, input logic a, input logic [31:0] d,
                     input logic [3:0] g, input logic [3:0] dn, input logic [3:0] e,
                     input logic [31:0] rd, input logic [31:0] ba, input logic br);
    vec_t v;
    v.req = r; v.ack = a; v.data = d;
    v.gnt = g; v.done = dn; v.err = e;
    v.rdata = rd; v.bus_ad = ba; v.bus_req = br;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] dn,
                           input logic [3:0] e, input logic [31:0] rd,
                           input logic [31:0] ba, input logic br);
    chk({tag, " gnt"},     32'(gnt_o),     32'(g));
    chk({tag, " done"},    32'(done_o),    32'(dn));
    chk({tag, " err"},     32'(err_o),     32'(e));
    chk({tag, " rdata"},   rdata_o,        rd);
    chk({tag, " bus_ad"},  bus_ad_o,       ba);
    chk({tag, " bus_req"}, 32'(bus_req_o), 32'(br));
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    ack     = 1'b0;
    data    = BAD;
    ad      = {A3, A2, A1, A0};

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 4'($urandom);
      ack = 1'($urandom);
      @(posedge clk); #1;
      check_all($sformatf("rst%0d", i), 4'b0, 4'b0, 4'b0, 32'h0, 32'h0, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    req     = '0;
    ack     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_all($sformatf("rel%0d", i), 4'b0, 4'b0, 4'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
    end

    // Fairness: all requesting, ack tied high; ptr starts at 0.
    add(4'b1111, 1, BAD,          4'b0001, 0, 0, 32'h0,          A0, 1);
    add(4'b1111, 1, 32'h1111_0001, 4'b0000, 4'b0001, 0, 32'h1111_0001, 0, 0);
    add(4'b1111, 1, BAD,          4'b0000, 0, 0, 32'h1111_0001, 0, 0);
    add(4'b1111, 1, BAD,          4'b0010, 0, 0, 32'h1111_0001, A1, 1);
    add(4'b1111, 1, 32'h1111_0002, 4'b0000, 4'b0010, 0, 32'h1111_0002, 0, 0);
    add(4'b1111, 1, BAD,          4'b0000, 0, 0, 32'h1111_0002, 0, 0);
    add(4'b1111, 1, BAD,          4'b0100, 0, 0, 32'h1111_0002, A2, 1);
    add(4'b1111, 1, 32'h1111_0003, 4'b0000, 4'b0100, 0, 32'h1111_0003, 0, 0);
    add(4'b1111, 1, BAD,          4'b0000, 0, 0, 32'h1111_0003, 0, 0);
    add(4'b1111, 1, BAD,          4'b1000, 0, 0, 32'h1111_0003, A3, 1);
    add(4'b1111, 1, 32'h1111_0004, 4'b0000, 4'b1000, 0, 32'h1111_0004, 0, 0);
    add(4'b1111, 1, BAD,          4'b0000, 0, 0, 32'h1111_0004, 0, 0);
    add(4'b1111, 1, BAD,          4'b0001, 0, 0, 32'h1111_0004, A0, 1);
    add(4'b1111, 1, 32'h1111_0005, 4'b0000, 4'b0001, 0, 32'h1111_0005, 0, 0);
    add(4'b1111, 1, BAD,          4'b0000, 0, 0, 32'h1111_0005, 0, 0);
    add(4'b1111, 1, BAD,          4'b0010, 0, 0, 32'h1111_0005, A1, 1);
    add(4'b0000, 1, 32'h1111_0006, 4'b0000, 4'b0010, 0, 32'h1111_0006, 0, 0);
    add(4'b0000, 0, BAD,          4'b0000, 0, 0, 32'h1111_0006, 0, 0);
    // Single request to 2, released during BUSY, ack on 4th BUSY cycle.
    add(4'b0100, 0, BAD,          4'b0100, 0, 0, 32'h1111_0006, A2, 1);
    add(4'b0000, 0, BAD,          4'b0100, 0, 0, 32'h1111_0006, A2, 1);
    add(4'b0000, 0, BAD,          4'b0100, 0, 0, 32'h1111_0006, A2, 1);
    add(4'b0000, 0, BAD,          4'b0100, 0, 0, 32'h1111_0006, A2, 1);
    add(4'b0000, 1, 32'hDEAD_BEEF, 4'b0000, 4'b0100, 0, 32'hDEAD_BEEF, 0, 0);
    add(4'b0000, 1, BAD,          4'b0000, 0, 0, 32'hDEAD_BEEF, 0, 0);
    add(4'b0000, 1, BAD,          4'b0000, 0, 0, 32'hDEAD_BEEF, 0, 0);
    // Timeout: five BUSY cycles, then err with rdata cleared.
    add(4'b0001, 0, BAD,          4'b0001, 0, 0, 32'hDEAD_BEEF, A0, 1);
    add(4'b0000, 0, BAD,          4'b0001, 0, 0, 32'hDEAD_BEEF, A0, 1);
    add(4'b0000, 0, BAD,          4'b0001, 0, 0, 32'hDEAD_BEEF, A0, 1);
    add(4'b0000, 0, BAD,          4'b0001, 0, 0, 32'hDEAD_BEEF, A0, 1);
    add(4'b0000, 0, BAD,          4'b0001, 0, 0, 32'hDEAD_BEEF, A0, 1);
    add(4'b0000, 0, BAD,          4'b0000, 4'b0001, 4'b0001, 32'h0, 0, 0);
    add(4'b0000, 0, BAD,          4'b0000, 0, 0, 32'h0, 0, 0);
    // Ack arrives exactly on the limit cycle: success.
    add(4'b0010, 0, BAD,          4'b0010, 0, 0, 32'h0, A1, 1);
    add(4'b0000, 0, BAD,          4'b0010, 0, 0, 32'h0, A1, 1);
    add(4'b0000, 0, BAD,          4'b0010, 0, 0, 32'h0, A1, 1);
    add(4'b0000, 0, BAD,          4'b0010, 0, 0, 32'h0, A1, 1);
    add(4'b0000, 0, BAD,          4'b0010, 0, 0, 32'h0, A1, 1);
    add(4'b0000, 1, 32'h1234_5678, 4'b0000, 4'b0010, 0, 32'h1234_5678, 0, 0);
    add(4'b0000, 0, BAD,          4'b0000, 0, 0, 32'h1234_5678, 0, 0);
    // Pointer at 2 with only 0 and 1 requesting: scan wraps to 0 first.
    add(4'b0011, 0, BAD,          4'b0001, 0, 0, 32'h1234_5678, A0, 1);
    add(4'b0011, 1, 32'h0000_00AA, 4'b0000, 4'b0001, 0, 32'h0000_00AA, 0, 0);
    add(4'b0011, 0, BAD,          4'b0000, 0, 0, 32'h0000_00AA, 0, 0);
    add(4'b0011, 0, BAD,          4'b0010, 0, 0, 32'h0000_00AA, A1, 1);
    add(4'b0000, 1, 32'h0000_00BB, 4'b0000, 4'b0010, 0, 32'h0000_00BB, 0, 0);
    add(4'b0000, 0, BAD,          4'b0000, 0, 0, 32'h0000_00BB, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      req  = vecs[i].req;
      ack  = vecs[i].ack;
      data = vecs[i].data;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].err,
                vecs[i].rdata, vecs[i].bus_ad, vecs[i].bus_req);
    end

    // Reset mid-BUSY for requester 3 (ptr is 2 here).
    @(negedge clk);
    req = 4'b1000; ack = 1'b0; data = BAD;
    @(posedge clk); #1;
    check_all("mid_grant", 4'b1000, 4'b0, 4'b0, 32'h0000_00BB, A3, 1'b1);
    @(negedge clk);
    req = 4'b0000;
    ad[127:96] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check_all("ad_hold", 4'b1000, 4'b0, 4'b0, 32'h0000_00BB, A3, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 4'b0, 4'b0, 4'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_all($sformatf("rst_hold%0d", i), 4'b0, 4'b0, 4'b0, 32'h0, 32'h0, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ad[127:96] = A3;
    req = 4'b1001;
    @(posedge clk); #1;
    check_all("post_rst_gnt", 4'b0001, 4'b0, 4'b0, 32'h0, A0, 1'b1);
    @(negedge clk);
    req = 4'b0000; ack = 1'b1; data = 32'h0000_0055;
    @(posedge clk); #1;
    check_all("post_rst_done", 4'b0, 4'b0001, 4'b0, 32'h0000_0055, 32'h0, 1'b0);
    @(negedge clk);
    ack = 1'b0; data = BAD;
    @(posedge clk); #1;
    check_all("post_rst_idle", 4'b0, 4'b0, 4'b0, 32'h0000_0055, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
